synaptic_weight_accumulator: RTL and testbench

//  Upstream feeder for the LIF potential adders. Accepts incoming spike events (source id), looks up per-target FP32

---
 rtl/snn_pkg.sv | 15 +
 rtl/synaptic_weight_accumulator_addsub.sv | 70 +++++++
 rtl/synaptic_weight_accumulator.sv | 147 ++++++++++++++
 tb/tb_synaptic_weight_accumulator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks.
//   FP32_ZERO / FP32_ONE : IEEE-754 single-precision constants
//   state_t              : accumulator controller states
package snn_pkg;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/synaptic_weight_accumulator_addsub.sv
// Combinational IEEE-754 single-precision add/subtract unit.
//   a, b      : operands
//   op        : 0 = a + b, 1 = a - b
//   result    : rounded-toward-zero sum; denormal inputs/outputs flush to +0
//   exception : an operand is Inf/NaN, or the result overflows
//               (result is then signed infinity)
module addition_subtraction (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] result,
  output logic        exception
);

  logic [7:0]        a_e, b_e, e_l, e_s;
  logic [23:0]       a_m, b_m, m_l, m_s;
  logic              b_s, s_l, s_s;
  logic [24:0]       m_al, sum;
  logic [22:0]       norm;
  logic [4:0]        lz;
  logic signed [9:0] e_n;
  logic              zero, ovf;

  always_comb begin
    a_e = a[30:23];
    b_e = b[30:23];
    a_m = (a_e != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
    b_m = (b_e != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
    b_s = b[31] ^ op;

    // Larger magnitude goes on the left so the aligned difference never goes negative.
    if (a[30:0] >= b[30:0]) begin
      s_l = a[31]; e_l = a_e; m_l = a_m;
      s_s = b_s;   e_s = b_e; m_s = b_m;
    end else begin
      s_l = b_s;   e_l = b_e; m_l = b_m;
      s_s = a[31]; e_s = a_e; m_s = a_m;
    end

    m_al = {1'b0, m_s} >> (e_l - e_s);
    sum  = (s_l ^ s_s) ? ({1'b0, m_l} - m_al) : ({1'b0, m_l} + m_al);
    e_n  = $signed({2'b00, e_l});

    // Highest set bit wins: the loop overwrites lz on each hit going upward.
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (sum[i]) lz = 5'(23 - i);
    end

    if (sum[24]) begin
      norm = sum[23:1];
      e_n  = e_n + 10'sd1;
    end else begin
      norm = sum[22:0] << lz;
      e_n  = e_n - $signed({5'd0, lz});
    end

    zero      = (sum == 25'd0) || (e_n <= 10'sd0);
    ovf       = (e_n >= 10'sd255);
    exception = (a_e == 8'hFF) || (b_e == 8'hFF) || (ovf && !zero);

    if (exception)
      result = {s_l, 8'hFF, 23'd0};
    else if (zero)
      result = 32'd0;
    else
      result = {s_l, e_n[7:0], norm};
  end

endmodule

// File: rtl/synaptic_weight_accumulator.sv
// Per-timestep synaptic input accumulator feeding the LIF potential adders.
// Spikes (source id) are expanded into per-neuron FP32 weight lookups and summed
// into one accumulator per target neuron; timestep_end streams the sums out over
// a valid/ready handshake and then clears them.
//   clk, rst (sync, active-high)
//   wt_wr_en/wt_wr_addr/wt_wr_data : weight-memory write port, {src, neuron} address, IDLE only
//   spike_valid/spike_ready/spike_src_id : spike event input
//   timestep_end : single-cycle pulse closing the timestep
//   out_valid/out_ready/out_neuron_id/out_weight/out_last : flush stream
//   acc_exception : sticky FP exception for the current timestep
//   busy          : not idle, or a flush is still owed
//
// state | meaning
// IDLE  | waiting for a spike or timestep close; weight writes accepted
// ACCUM | adding w[src][n] into acc[n], one neuron per cycle
// FLUSH | presenting acc[k] downstream, advancing on out_ready
module synaptic_weight_accumulator
  import snn_pkg::*;
#(
  parameter int N_SRC     = 16,
  parameter int N_NEURONS = 4,
  parameter int SRC_W     = 4,
  parameter int NID_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wt_wr_en,
  input  logic [SRC_W+NID_W-1:0] wt_wr_addr,
  input  logic [31:0]            wt_wr_data,
  input  logic                   spike_valid,
  output logic                   spike_ready,
  input  logic [SRC_W-1:0]       spike_src_id,
  input  logic                   timestep_end,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NID_W-1:0]       out_neuron_id,
  output logic [31:0]            out_weight,
  output logic                   out_last,
  output logic                   acc_exception,
  output logic                   busy
);

  localparam logic [NID_W-1:0] LAST_N = NID_W'(N_NEURONS - 1);

  state_t             state, state_nx;
  logic [SRC_W-1:0]   src_q;
  logic [NID_W-1:0]   n_q, k_q;
  logic               pending_end;
  logic [31:0]        acc  [N_NEURONS];
  logic [31:0]        wmem [N_SRC*N_NEURONS];
  logic [31:0]        add_result;
  logic               add_exc;

  addition_subtraction u_add (
    .a         (acc[n_q]),
    .b         (wmem[{src_q, n_q}]),
    .op        (1'b0),
    .result    (add_result),
    .exception (add_exc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A spike accepted in the same cycle as timestep_end belongs to the closing
  // timestep, so ready ignores the pulse itself; pending_end then forces the
  // flush once the spike's accumulation completes.
  always_comb begin
    state_nx      = state;
    spike_ready   = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    out_neuron_id = '0;
    out_weight    = FP32_ZERO;
    case (state)
      IDLE: begin
        spike_ready = !pending_end && !rst;
        if (spike_valid && spike_ready)    state_nx = ACCUM;
        else if (pending_end || timestep_end) state_nx = FLUSH;
      end
      ACCUM: begin
        if (n_q == LAST_N) state_nx = IDLE;
      end
      FLUSH: begin
        out_valid     = 1'b1;
        out_neuron_id = k_q;
        out_weight    = acc[k_q];
        out_last      = (k_q == LAST_N);
        if (out_ready && k_q == LAST_N) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // pending_end is consumed on entry to FLUSH so a pulse arriving during the
  // flush survives and schedules a second (empty) flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q         <= '0;
      n_q           <= '0;
      k_q           <= '0;
      pending_end   <= 1'b0;
      acc_exception <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) acc[i] <= FP32_ZERO;
    end else begin
      pending_end <= pending_end | timestep_end;
      case (state)
        IDLE: begin
          if (spike_valid && spike_ready) begin
            src_q <= spike_src_id;
            n_q   <= '0;
          end else if (pending_end || timestep_end) begin
            pending_end <= 1'b0;
            k_q         <= '0;
          end
        end
        ACCUM: begin
          acc[n_q] <= add_result;
          if (add_exc) acc_exception <= 1'b1;
          n_q <= n_q + 1'b1;
        end
        FLUSH: begin
          if (out_ready) begin
            if (k_q == LAST_N) begin
              k_q           <= '0;
              acc_exception <= 1'b0;
              for (int i = 0; i < N_NEURONS; i++) acc[i] <= FP32_ZERO;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Weight memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && wt_wr_en) wmem[wt_wr_addr] <= wt_wr_data;
  end

  assign busy = (state != IDLE) || pending_end;

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
module tb_synaptic_weight_accumulator;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wt_wr_en;
  logic [5:0]  wt_wr_addr;
  logic [31:0] wt_wr_data;
  logic        spike_valid;
  logic        spike_ready;
  logic [3:0]  spike_src_id;
  logic        timestep_end;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_neuron_id;
  logic [31:0] out_weight;
  logic        out_last;
  logic        acc_exception;
  logic        busy;

  int total = 0;
  int bad   = 0;

  synaptic_weight_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .wt_wr_en      (wt_wr_en),
    .wt_wr_addr    (wt_wr_addr),
    .wt_wr_data    (wt_wr_data),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .spike_src_id  (spike_src_id),
    .timestep_end  (timestep_end),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_neuron_id (out_neuron_id),
    .out_weight    (out_weight),
    .out_last      (out_last),
    .acc_exception (acc_exception),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        src_a;
    int                cnt_a;
    logic [3:0]        src_b;
    int                cnt_b;
    logic [3:0][31:0]  exp_w;   // {n3, n2, n1, n0}
    string             name;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    wt_wr_en   = 1'b1;
    wt_wr_addr = addr;
    wt_wr_data = data;
    step();
    wt_wr_en   = 1'b0;
  endtask

  task automatic send_spike(input logic [3:0] src);
    int c = 0;
    spike_valid  = 1'b1;
    spike_src_id = src;
    while (!spike_ready && c < 50) begin step(); c++; end
    if (!spike_ready) chk("spike_ready_timeout", 32'(spike_ready), 32'd1);
    step();
    spike_valid = 1'b0;
  endtask

  task automatic pulse_end();
    timestep_end = 1'b1;
    step();
    timestep_end = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!out_valid && c < 50) begin step(); c++; end
    if (!out_valid) chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
  endtask

  task automatic flush_check(input logic [3:0][31:0] ew, input logic exc_exp, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid(tag);
      chk({tag, "_id"},   32'(out_neuron_id), 32'(k));
      chk({tag, "_w"},    out_weight, ew[k]);
      chk({tag, "_last"}, 32'(out_last), 32'(k == 3));
      chk({tag, "_exc"},  32'(acc_exception), 32'(exc_exp));
      step();
    end
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_exc_after"},   32'(acc_exception), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs, low, cyc, seen;

    vecs[0] = '{4'd0, 2, 4'd0, 0, {32'h0, 32'h0, 32'h40800000, 32'h40000000}, "v_src0x2"};
    vecs[1] = '{4'd1, 1, 4'd2, 1, {32'h40600000, 32'h3F800000, 32'h0, 32'h40000000}, "v_src1_src2"};
    vecs[2] = '{4'd0, 1, 4'd2, 2, {FP32_ONE, 32'h0, 32'h40000000, 32'h40A00000}, "v_src0_src2x2"};
    vecs[3] = '{4'd5, 0, 4'd6, 0, {FP32_ZERO, FP32_ZERO, FP32_ZERO, FP32_ZERO}, "v_empty"};

    rst = 1'b1; wt_wr_en = 1'b0; wt_wr_addr = '0; wt_wr_data = '0;
    spike_valid = 1'b0; spike_src_id = '0; timestep_end = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_last",   32'(out_last), 32'd0);
    chk("rst_weight", out_weight, 32'd0);
    chk("rst_id",     32'(out_neuron_id), 32'd0);
    chk("rst_exc",    32'(acc_exception), 32'd0);
    chk("rst_ready",  32'(spike_ready), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 64; i++) wr(6'(i), FP32_ZERO);
    wr({4'd0, 2'd0}, FP32_ONE);
    wr({4'd0, 2'd1}, 32'h40000000);
    wr({4'd1, 2'd2}, FP32_ONE);
    wr({4'd1, 2'd3}, 32'h40400000);
    wr({4'd2, 2'd0}, 32'h40000000);
    wr({4'd2, 2'd3}, 32'h3F000000);
    chk("idle_ready", 32'(spike_ready), 32'd1);

    // table-driven timesteps
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < vecs[v].cnt_a; j++) send_spike(vecs[v].src_a);
      for (int j = 0; j < vecs[v].cnt_b; j++) send_spike(vecs[v].src_b);
      pulse_end();
      flush_check(vecs[v].exp_w, 1'b0, vecs[v].name);
    end

    // spike_valid held: each accepted spike keeps ready low for four cycles
    spike_src_id = 4'd0; spike_valid = 1'b1; hs = 0; low = 0; cyc = 0;
    while (hs < 3 && cyc < 60) begin
      if (spike_ready) begin
        if (hs > 0) chk("held_gap", 32'(low), 32'd4);
        hs++;
        low = 0;
      end else begin
        low++;
      end
      step();
      cyc++;
    end
    spike_valid = 1'b0;
    chk("held_count", 32'(hs), 32'd3);
    pulse_end();
    flush_check({32'h0, 32'h0, 32'h40C00000, 32'h40400000}, 1'b0, "held");

    // spike accepted in the same cycle as timestep_end joins the closing flush
    spike_valid = 1'b1; spike_src_id = 4'd1; timestep_end = 1'b1;
    chk("same_ready", 32'(spike_ready), 32'd1);
    step();
    spike_valid = 1'b0; timestep_end = 1'b0;
    chk("same_busy", 32'(busy), 32'd1);
    flush_check({32'h40400000, FP32_ONE, 32'h0, 32'h0}, 1'b0, "same");
    step();
    chk("same_idle_busy", 32'(busy), 32'd0);

    // downstream stall at k=1
    send_spike(4'd0);
    pulse_end();
    out_ready = 1'b1;
    wait_valid("stall");
    chk("stall_k0_id", 32'(out_neuron_id), 32'd0);
    chk("stall_k0_w",  out_weight, FP32_ONE);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_id",    32'(out_neuron_id), 32'd1);
      chk("stall_hold_w",     out_weight, 32'h40000000);
      step();
    end
    out_ready = 1'b1;
    chk("stall_rel_id", 32'(out_neuron_id), 32'd1);
    step();
    chk("stall_k2_id", 32'(out_neuron_id), 32'd2);
    chk("stall_k2_w",  out_weight, 32'h0);
    step();
    chk("stall_k3_id",   32'(out_neuron_id), 32'd3);
    chk("stall_k3_last", 32'(out_last), 32'd1);
    step();
    chk("stall_done", 32'(out_valid), 32'd0);

    // reset in the middle of accumulation
    send_spike(4'd2);
    step();
    rst = 1'b1;
    step();
    chk("mrst_ready", 32'(spike_ready), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy",  32'(busy), 32'd0);
    chk("mrst_exc",   32'(acc_exception), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mrst_no_valid", 32'(seen), 32'd0);
    pulse_end();
    flush_check({FP32_ZERO, FP32_ZERO, FP32_ZERO, FP32_ZERO}, 1'b0, "mrst");

    // +inf weight raises the sticky exception; writes during ACCUM are dropped
    wr({4'd3, 2'd1}, 32'h7F800000);
    send_spike(4'd3);
    wr({4'd0, 2'd0}, 32'h41200000);
    cyc = 0;
    while (busy && cyc < 20) begin step(); cyc++; end
    chk("inf_exc_set", 32'(acc_exception), 32'd1);
    pulse_end();
    flush_check({32'h0, 32'h0, 32'h7F800000, 32'h0}, 1'b1, "inf");
    send_spike(4'd0);
    pulse_end();
    flush_check({32'h0, 32'h0, 32'h40000000, FP32_ONE}, 1'b0, "drop_wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
